// File: rtl/unified_load_logic.sv
// Read-side butterfly operand fetch: generates conflict-free index pairs for one
// FFT/NTT stage, issues paired bank reads and realigns returned words into a/b operands.
module unified_load_logic #(
  parameter int ADDR_WIDTH = 12,
  parameter int BRAM_LAT   = 2,
  parameter int LOGQ       = 54,
  parameter int CPLX_W     = 64,
  parameter int SW         = $clog2(ADDR_WIDTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SW-1:0]         stage,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic                  rea_0,
  output logic                  rea_1,
  input  logic [CPLX_W-1:0]     data_from_bram_0,
  input  logic [CPLX_W-1:0]     data_from_bram_1,
  input  logic [LOGQ-1:0]       data_from_bram_2,
  input  logic [LOGQ-1:0]       data_from_bram_3,
  input  logic [LOGQ-1:0]       data_from_bram_4,
  input  logic [LOGQ-1:0]       data_from_bram_5,
  output logic [CPLX_W-1:0]     a_cplx,
  output logic [CPLX_W-1:0]     b_cplx,
  output logic [LOGQ-1:0]       a_ntt_1,
  output logic [LOGQ-1:0]       b_ntt_1,
  output logic [LOGQ-1:0]       a_ntt_2,
  output logic [LOGQ-1:0]       b_ntt_2,
  output logic                  valid_out,
  output logic                  dest_bank_a,
  output logic                  dest_bank_b,
  output logic [ADDR_WIDTH-1:0] dest_addr_a,
  output logic [ADDR_WIDTH-1:0] dest_addr_b
);

  localparam int LOG_N = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   k_r;
  logic [SW-1:0]           stage_r;
  logic                    accept_s, issue_s, finish_s, in_flight_s;

  logic [LOG_N-1:0]        k_ext_s, half_s, low_mask_s, idx_a_s, idx_b_s;
  logic                    bank_a_s;
  logic [ADDR_WIDTH-1:0]   addr_a_s, addr_b_s;

  // Issue-stage side info; bank of idx_a doubles as the swap flag.
  logic                    swap_r;
  logic [ADDR_WIDTH-1:0]   iss_addr_a_r, iss_addr_b_r;

  logic [BRAM_LAT-1:0]                 pv_r, psw_r;
  logic [BRAM_LAT-1:0][ADDR_WIDTH-1:0] paa_r, pab_r;

  assign k_ext_s    = {1'b0, k_r};
  assign half_s     = LOG_N'(1) << stage_r;
  assign low_mask_s = half_s - LOG_N'(1);
  assign idx_a_s    = ((k_ext_s >> stage_r) << (stage_r + SW'(1))) | (k_ext_s & low_mask_s);
  assign idx_b_s    = idx_a_s | half_s;
  assign bank_a_s   = ^idx_a_s;
  assign addr_a_s   = idx_a_s[LOG_N-1:1];
  assign addr_b_s   = idx_b_s[LOG_N-1:1];

  assign in_flight_s = rea_0 | (|pv_r);

  // Next-state and issue/finish decisions
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    issue_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (stage <= SW'(ADDR_WIDTH))) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          issue_s = 1'b1;
          if (k_r == {ADDR_WIDTH{1'b1}}) begin
            state_s = DRAIN;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (!in_flight_s) begin
          finish_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counter, issue registers, return pipeline and operand outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      k_r          <= {ADDR_WIDTH{1'b0}};
      stage_r      <= {SW{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      rea_0        <= 1'b0;
      rea_1        <= 1'b0;
      read_addr_0  <= {ADDR_WIDTH{1'b0}};
      read_addr_1  <= {ADDR_WIDTH{1'b0}};
      swap_r       <= 1'b0;
      iss_addr_a_r <= {ADDR_WIDTH{1'b0}};
      iss_addr_b_r <= {ADDR_WIDTH{1'b0}};
      pv_r         <= '0;
      psw_r        <= '0;
      paa_r        <= '0;
      pab_r        <= '0;
      valid_out    <= 1'b0;
      a_cplx       <= {CPLX_W{1'b0}};
      b_cplx       <= {CPLX_W{1'b0}};
      a_ntt_1      <= {LOGQ{1'b0}};
      b_ntt_1      <= {LOGQ{1'b0}};
      a_ntt_2      <= {LOGQ{1'b0}};
      b_ntt_2      <= {LOGQ{1'b0}};
      dest_bank_a  <= 1'b0;
      dest_bank_b  <= 1'b0;
      dest_addr_a  <= {ADDR_WIDTH{1'b0}};
      dest_addr_b  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      done    <= finish_s;
      rea_0   <= issue_s;
      rea_1   <= issue_s;

      if (accept_s) begin
        k_r     <= {ADDR_WIDTH{1'b0}};
        stage_r <= stage;
        busy    <= 1'b1;
      end else if (issue_s) begin
        k_r     <= k_r + ADDR_WIDTH'(1);
      end else if (finish_s) begin
        busy    <= 1'b0;
      end

      if (issue_s) begin
        swap_r       <= bank_a_s;
        iss_addr_a_r <= addr_a_s;
        iss_addr_b_r <= addr_b_s;
        read_addr_0  <= bank_a_s ? addr_b_s : addr_a_s;
        read_addr_1  <= bank_a_s ? addr_a_s : addr_b_s;
      end

      pv_r[0]  <= rea_0;
      psw_r[0] <= swap_r;
      paa_r[0] <= iss_addr_a_r;
      pab_r[0] <= iss_addr_b_r;
      for (int j = 1; j < BRAM_LAT; j++) begin
        pv_r[j]  <= pv_r[j-1];
        psw_r[j] <= psw_r[j-1];
        paa_r[j] <= paa_r[j-1];
        pab_r[j] <= pab_r[j-1];
      end

      // Last pipe entry lines up with the BRAM words of the same butterfly.
      valid_out <= pv_r[BRAM_LAT-1];
      if (pv_r[BRAM_LAT-1]) begin
        a_cplx      <= psw_r[BRAM_LAT-1] ? data_from_bram_1 : data_from_bram_0;
        b_cplx      <= psw_r[BRAM_LAT-1] ? data_from_bram_0 : data_from_bram_1;
        a_ntt_1     <= psw_r[BRAM_LAT-1] ? data_from_bram_3 : data_from_bram_2;
        b_ntt_1     <= psw_r[BRAM_LAT-1] ? data_from_bram_2 : data_from_bram_3;
        a_ntt_2     <= psw_r[BRAM_LAT-1] ? data_from_bram_5 : data_from_bram_4;
        b_ntt_2     <= psw_r[BRAM_LAT-1] ? data_from_bram_4 : data_from_bram_5;
        dest_bank_a <= psw_r[BRAM_LAT-1];
        dest_bank_b <= ~psw_r[BRAM_LAT-1];
        dest_addr_a <= paa_r[BRAM_LAT-1];
        dest_addr_b <= pab_r[BRAM_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_unified_load_logic.sv
// Directed bench for unified_load_logic (ADDR_WIDTH=3, N=16) with a 2-cycle BRAM model
// whose words encode the element index they hold.
module tb_unified_load_logic;

  localparam int AW = 3;
  localparam int LQ = 54;
  localparam int CW = 64;
  localparam int SWB = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SWB-1:0]  stage = 3'd0;
  logic            stall = 1'b0;
  logic            busy, done, rea_0, rea_1, valid_out;
  logic [AW-1:0]   read_addr_0, read_addr_1;
  logic [CW-1:0]   d0, d1, a_cplx, b_cplx;
  logic [LQ-1:0]   d2, d3, d4, d5, a_ntt_1, b_ntt_1, a_ntt_2, b_ntt_2;
  logic            dest_bank_a, dest_bank_b;
  logic [AW-1:0]   dest_addr_a, dest_addr_b;
  logic [AW-1:0]   p0, p1;

  int checks = 0;
  int errors = 0;

  int rea_cnt, val_cnt, done_cnt, done_rel, gaps, busy0;
  int seen [16];
  logic [AW-1:0] ra0 [8];
  logic [AW-1:0] ra1 [8];

  always #5 clk = ~clk;

  unified_load_logic #(.ADDR_WIDTH(AW), .BRAM_LAT(2), .LOGQ(LQ), .CPLX_W(CW), .SW(SWB)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .stall(stall),
    .busy(busy), .done(done),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1), .rea_0(rea_0), .rea_1(rea_1),
    .data_from_bram_0(d0), .data_from_bram_1(d1), .data_from_bram_2(d2),
    .data_from_bram_3(d3), .data_from_bram_4(d4), .data_from_bram_5(d5),
    .a_cplx(a_cplx), .b_cplx(b_cplx), .a_ntt_1(a_ntt_1), .b_ntt_1(b_ntt_1),
    .a_ntt_2(a_ntt_2), .b_ntt_2(b_ntt_2), .valid_out(valid_out),
    .dest_bank_a(dest_bank_a), .dest_bank_b(dest_bank_b),
    .dest_addr_a(dest_addr_a), .dest_addr_b(dest_addr_b)
  );

  // Bank 0/2/4 at addr a holds index {a, ^a}; bank 1/3/5 holds {a, ~^a}.
  always @(posedge clk) begin
    if (rea_0) p0 <= read_addr_0;
    if (rea_1) p1 <= read_addr_1;
    d0 <= 64'hC000 + 64'({p0, ^p0});
    d1 <= 64'hC000 + 64'({p1, ~^p1});
    d2 <= 54'h200 + 54'({p0, ^p0});
    d3 <= 54'h200 + 54'({p1, ~^p1});
    d4 <= 54'h400 + 54'({p0, ^p0});
    d5 <= 54'h400 + 54'({p1, ~^p1});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ia(input int s, input int k);
    int v;
    v = ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
    return v[3:0];
  endfunction

  task automatic run_stage(input int s, input int st_lo, input int st_hi,
                           input int hold, input int rst_at);
    int kv, first_v, last_v;
    logic [3:0] ea, eb;
    rea_cnt = 0; val_cnt = 0; done_cnt = 0; done_rel = -1; kv = 0;
    first_v = -1; last_v = -1;
    for (int i = 0; i < 16; i++) seen[i] = 0;
    @(negedge clk);
    start = 1'b1;
    stage = SWB'(s);
    @(posedge clk);
    for (int rel = 0; rel < 30; rel++) begin
      @(negedge clk);
      if (rel == 0) busy0 = int'(busy);
      if (rst_at >= 0 && rel == rst_at + 1) begin
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid_out), 64'd0);
      end
      if (rea_0 || rea_1) begin
        if (rea_cnt < 8) begin
          ra0[rea_cnt] = read_addr_0;
          ra1[rea_cnt] = read_addr_1;
        end
        rea_cnt++;
        seen[{read_addr_0, ^read_addr_0}]++;
        seen[{read_addr_1, ~^read_addr_1}]++;
      end
      if (valid_out) begin
        ea = ia(s, kv);
        eb = ea | 4'(1 << s);
        chk("a_cplx", a_cplx, 64'hC000 + 64'(ea));
        chk("b_cplx", b_cplx, 64'hC000 + 64'(eb));
        chk("ntt1_ab", {5'd0, a_ntt_1[8:0], 5'd0, b_ntt_1[8:0]}, {5'd0, 9'h200 + 9'(ea), 5'd0, 9'h200 + 9'(eb)});
        chk("ntt2_ab", {5'd0, a_ntt_2[10:0], 5'd0, b_ntt_2[10:0]}, {5'd0, 11'h400 + 11'(ea), 5'd0, 11'h400 + 11'(eb)});
        chk("dest_bank", {dest_bank_a, dest_bank_b}, {^ea, ^eb});
        chk("dest_addr", {dest_addr_a, dest_addr_b}, {ea[3:1], eb[3:1]});
        val_cnt++;
        kv++;
        if (first_v < 0) first_v = rel;
        last_v = rel;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      start = (rel < hold);
      stall = (rel >= st_lo && rel <= st_hi);
      rst   = (rel == rst_at);
    end
    start = 1'b0; stall = 1'b0; rst = 1'b0;
    gaps = (first_v >= 0) ? (last_v - first_v + 1 - val_cnt) : 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, done, rea_0, rea_1, valid_out}, 64'd0);
    chk("rst_addr", {read_addr_0, read_addr_1, dest_addr_a, dest_addr_b, dest_bank_a, dest_bank_b}, 64'd0);
    chk("rst_data", a_cplx | b_cplx | 64'(a_ntt_1) | 64'(b_ntt_2), 64'd0);
    rst = 1'b0;

    // Stage 0, no stall
    run_stage(0, -1, -1, 0, -1);
    chk("s0_busy_t0", 64'(busy0), 64'd1);
    chk("s0_rea_cnt", 64'(rea_cnt), 64'd8);
    chk("s0_val_cnt", 64'(val_cnt), 64'd8);
    chk("s0_done_cnt", 64'(done_cnt), 64'd1);
    chk("s0_done_t", 64'(done_rel), 64'd12);
    chk("s0_gaps", 64'(gaps), 64'd0);
    chk("s0_issue0", {ra0[0], ra1[0]}, {3'd0, 3'd0});
    chk("s0_issue1", {ra0[1], ra1[1]}, {3'd1, 3'd1});
    for (int i = 0; i < 16; i++) chk($sformatf("s0_seen%0d", i), 64'(seen[i]), 64'd1);
    chk("s0_busy_end", 64'(busy), 64'd0);

    // Stage 3: k=5 reads bank0 addr 2, bank1 addr 6
    run_stage(3, -1, -1, 0, -1);
    chk("s3_k5", {ra0[5], ra1[5]}, {3'd2, 3'd6});
    chk("s3_done_t", 64'(done_rel), 64'd12);
    for (int i = 0; i < 16; i++) chk($sformatf("s3_seen%0d", i), 64'(seen[i]), 64'd1);

    // Stage 1 with stall during t0+3..t0+5
    run_stage(1, 3, 5, 0, -1);
    chk("st_rea_cnt", 64'(rea_cnt), 64'd8);
    chk("st_val_cnt", 64'(val_cnt), 64'd8);
    chk("st_gaps", 64'(gaps), 64'd3);
    chk("st_done_t", 64'(done_rel), 64'd15);
    for (int i = 0; i < 16; i++) chk($sformatf("st_seen%0d", i), 64'(seen[i]), 64'd1);

    // Out-of-range stage is ignored
    @(negedge clk);
    start = 1'b1;
    stage = 3'd4;
    @(negedge clk);
    start = 1'b0;
    chk("bad_stage_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("bad_stage_idle", {busy, rea_0, rea_1, done}, 64'd0);

    // Start held high during a run does not restart it
    run_stage(2, -1, -1, 6, -1);
    chk("hold_rea_cnt", 64'(rea_cnt), 64'd8);
    chk("hold_done_cnt", 64'(done_cnt), 64'd1);
    chk("hold_done_t", 64'(done_rel), 64'd12);

    // Reset mid-operation at edge t0+4
    run_stage(0, -1, -1, 0, 3);
    chk("mid_rst_rea", 64'(rea_cnt), 64'd3);
    chk("mid_rst_val", 64'(val_cnt), 64'd0);
    chk("mid_rst_done", 64'(done_cnt), 64'd0);

    // Recovery after reset
    run_stage(0, -1, -1, 0, -1);
    chk("rec_done_t", 64'(done_rel), 64'd12);
    chk("rec_val_cnt", 64'(val_cnt), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
